sio_cmd_queue: RTL and testbench

//  Command queue and sequencer directly upstream of sio_host. Accepts 80-bit

---
 rtl/sio_cmd_queue.sv | 163 ++++++++++++++++
 tb/tb_sio_cmd_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sio_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : sio_cmd_queue
//  Description : Command FIFO and one-at-a-time sequencer in front of
//                sio_host. Buffers 80-bit write commands, issues each as a
//                single-cycle h_wvalid pulse, waits one serial frame, captures
//                h_rdata and returns it as a 32-bit valid/ready response.
//  Ports       : c            clock (shared with sio_host)
//                rst_n        asynchronous active-low reset
//                in_data/in_valid/in_ready   command input, valid/ready
//                level        number of queued (not yet issued) commands
//                h_wdata/h_wvalid            command to sio_host
//                h_rdata      read data from sio_host
//                resp_data/resp_valid/resp_ready  response output
//                busy         sequencer active or commands queued
//  Revision    : 1.0  initial release
// ============================================================================
module sio_cmd_queue #(
    parameter int DEPTH        = 8,
    parameter int FRAME_CYCLES = 48
) (
    input  logic                   c,
    input  logic                   rst_n,
    input  logic [79:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [79:0]            h_wdata,
    output logic                   h_wvalid,
    input  logic [31:0]            h_rdata,
    output logic [31:0]            resp_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   busy
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [15:0] C_LAST  = 16'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q,      state_d;
    logic [AW-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [AW:0]     level_q,      level_d;
    logic            in_ready_q,   in_ready_d;
    logic [79:0]     h_wdata_q,    h_wdata_d;
    logic            h_wvalid_q,   h_wvalid_d;
    logic [31:0]     resp_data_q,  resp_data_d;
    logic            resp_valid_q, resp_valid_d;
    logic [15:0]     timer_q,      timer_d;

    logic [79:0]     mem_q [DEPTH];
    logic            w_push;
    logic            w_pop;

    // ------------------------------------------------------------------
    // FIFO bookkeeping. in_ready is a flop derived from the next level, so
    // a pop out of a full FIFO only re-opens the input on the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_push     = in_valid && in_ready_q;
        w_pop      = (state_q == S_IDLE) && (level_q != '0);
        wr_ptr_d   = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - (AW+1)'(1);
        end
        in_ready_d = (level_d != C_DEPTH);
    end

    // Storage has no reset: entries are only read after being written.
    always_ff @(posedge c) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: one command in flight; the frame timer counts from the
    // issue edge so the capture lands FRAME_CYCLES after the pulse rises.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        h_wdata_d    = h_wdata_q;
        h_wvalid_d   = 1'b0;
        timer_d      = timer_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    h_wdata_d  = mem_q[rd_ptr_q];
                    h_wvalid_d = 1'b1;
                    timer_d    = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == C_LAST) begin
                    resp_data_d  = h_rdata;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            in_ready_q   <= 1'b1;
            h_wdata_q    <= '0;
            h_wvalid_q   <= 1'b0;
            timer_q      <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            in_ready_q   <= in_ready_d;
            h_wdata_q    <= h_wdata_d;
            h_wvalid_q   <= h_wvalid_d;
            timer_q      <= timer_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign level      = level_q;
    assign h_wdata    = h_wdata_q;
    assign h_wvalid   = h_wvalid_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_sio_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sio_cmd_queue
//  Description : Scoreboard bench for sio_cmd_queue. Stimulus pushes expected
//                issue data and responses into queues; monitors pop and compare
//                when the DUT presents h_wvalid or a response handshake. A small
//                sio_host stand-in returns wdata[31:0] ^ MASK, valid only in the
//                cycle the queue is expected to capture it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sio_cmd_queue;

    localparam int          DEPTH = 8;
    localparam int          F     = 48;
    localparam logic [31:0] MASK  = 32'hCAFE_1235;
    localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

    logic        c = 1'b0;
    logic        rst_n = 1'b0;
    logic [79:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  level;
    logic [79:0] h_wdata;
    logic        h_wvalid;
    logic [31:0] h_rdata;
    logic [31:0] resp_data;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        busy;

    sio_cmd_queue #(.DEPTH(DEPTH), .FRAME_CYCLES(F)) dut (
        .c          (c),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .level      (level),
        .h_wdata    (h_wdata),
        .h_wvalid   (h_wvalid),
        .h_rdata    (h_rdata),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 c = ~c;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_pulses = 0;
    int          epoch    = 0;
    int          max_level = 0;
    logic        saw_full = 1'b0;
    logic [79:0] exp_cmd_q [$];
    logic [31:0] exp_resp_q [$];
    int          pulse_cyc [$];

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
    endtask

    initial forever begin
        @(posedge c);
        cyc++;
    end

    // Issue / response / FIFO-flag monitor
    logic prev_wv = 1'b0;
    initial forever begin
        @(negedge c);
        if (rst_n && h_wvalid) begin
            check("pulse_width", {79'b0, prev_wv}, 80'd0);
            if (exp_cmd_q.size() == 0) fail_now("issue_unexpected");
            else check("issue_data", h_wdata, exp_cmd_q.pop_front());
            pulse_cyc.push_back(cyc);
            n_pulses++;
        end
        prev_wv = h_wvalid;
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_resp_q.size() == 0) fail_now("resp_unexpected");
            else check("resp_data", resp_data, exp_resp_q.pop_front());
        end
        if (rst_n) begin
            check("in_ready_vs_level", in_ready, level != 4'(DEPTH));
            if (int'(level) > max_level) max_level = int'(level);
            if (!in_ready) saw_full = 1'b1;
        end
    end

    // sio_host stand-in: rdata is only meaningful in the capture cycle
    int          h_ep;
    logic [31:0] h_d;
    initial begin
        h_rdata = JUNK;
        forever begin
            @(negedge c);
            if (rst_n && h_wvalid) begin
                h_ep = epoch;
                h_d  = h_wdata[31:0] ^ MASK;
                repeat (F - 1) @(posedge c);
                #1;
                h_rdata = h_d;
                if (h_ep == epoch && rst_n) check("resp_not_early", resp_valid, 80'd0);
                @(posedge c);
                #1;
                h_rdata = JUNK;
                if (h_ep == epoch && rst_n) check("resp_latency", resp_valid, 80'd1);
            end
        end
    end

    task automatic push(input logic [79:0] cmd);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        in_data  = cmd;
        in_valid = 1'b1;
        while (!acc && n < 3000) begin
            @(negedge c);
            acc = in_ready;
            @(posedge c);
            n++;
        end
        if (!acc) fail_now("push_accept");
        else begin
            exp_cmd_q.push_back(cmd);
            exp_resp_q.push_back(cmd[31:0] ^ MASK);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (n_pulses < n && k < budget) begin
            @(posedge c);
            k++;
        end
        if (n_pulses < n) fail_now(name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while ((busy || exp_resp_q.size() != 0) && k < budget) begin
            @(posedge c);
            k++;
        end
        if (busy || exp_resp_q.size() != 0) fail_now(name);
        #1;
    endtask

    int   p0;
    int   n0;
    int   x0;
    int   k;
    logic [31:0] rd_a;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge c);
        #1;
        check("rst_level",      level,      80'd0);
        check("rst_in_ready",   in_ready,   80'd1);
        check("rst_h_wvalid",   h_wvalid,   80'd0);
        check("rst_h_wdata",    h_wdata,    80'd0);
        check("rst_resp_valid", resp_valid, 80'd0);
        check("rst_resp_data",  resp_data,  80'd0);
        check("rst_busy",       busy,       80'd0);
        @(negedge c);
        rst_n = 1'b1;
        repeat (2) @(posedge c);
        #1;

        // ---------------- single command ----------------
        p0 = n_pulses;
        push(80'h1_0000_0000_0000_1234);
        n0 = cyc;
        wait_pulses(p0 + 1, 10, "single_pulse_wait");
        if (n_pulses > p0) check("single_pulse_cycle", pulse_cyc[p0], n0 + 1);
        k = 0;
        while (!resp_valid && k < 200) begin
            @(negedge c);
            k++;
        end
        if (!resp_valid) fail_now("single_resp_wait");
        else begin
            check("single_resp_value", resp_data, 80'h0000_CAFE_0001);
            if (n_pulses > p0) check("single_resp_cycle", cyc, pulse_cyc[p0] + F);
        end
        wait_idle(200, "single_drain");

        // ---------------- reset mid-frame ----------------
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) push(80'hA0_0000_0000_0000_0000 | 80'(i));
        wait_pulses(p0 + 1, 20, "rst_test_pulse");
        repeat (20) @(posedge c);
        #1;
        check("pre_rst_level", level, 80'd3);
        @(negedge c);
        rst_n = 1'b0;
        epoch++;
        exp_cmd_q.delete();
        exp_resp_q.delete();
        #1;
        check("midrst_level",      level,      80'd0);
        check("midrst_in_ready",   in_ready,   80'd1);
        check("midrst_h_wvalid",   h_wvalid,   80'd0);
        check("midrst_resp_valid", resp_valid, 80'd0);
        check("midrst_busy",       busy,       80'd0);
        repeat (3) @(negedge c);
        rst_n = 1'b1;
        p0 = n_pulses;
        repeat (200) @(posedge c);
        #1;
        check("no_pulse_after_rst", n_pulses, p0);
        check("idle_after_rst", busy, 80'd0);

        // ---------------- burst to full ----------------
        max_level = 0;
        saw_full  = 1'b0;
        resp_ready = 1'b1;
        p0 = n_pulses;
        for (int i = 0; i < 10; i++) push({16'h0B00 + 16'(i), 32'h1111_0000 + 32'(i), 32'h5000_0000 + 32'(i * 3)});
        wait_idle(1500, "burst_drain");
        check("burst_max_level", max_level, 80'd8);
        check("burst_in_ready_dropped", saw_full, 80'd1);
        check("burst_pulse_count", n_pulses - p0, 80'd10);
        for (int i = 1; i < 10; i++) begin
            if (p0 + i < n_pulses)
                check("burst_spacing", pulse_cyc[p0 + i] - pulse_cyc[p0 + i - 1], 80'(F + 2));
        end

        // ---------------- response backpressure ----------------
        resp_ready = 1'b0;
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) push({16'h0C0C, 32'h0, 32'h7700_0000 + 32'(i)});
        repeat (100) @(posedge c);
        #1;
        rd_a = resp_data;
        repeat (400) @(posedge c);
        #1;
        check("bp_one_pulse", n_pulses - p0, 80'd1);
        check("bp_resp_valid_held", resp_valid, 80'd1);
        check("bp_resp_stable", resp_data, rd_a);
        check("bp_resp_value", resp_data, 80'(32'h7700_0000 ^ MASK));
        check("bp_level", level, 80'd3);
        x0 = cyc;
        resp_ready = 1'b1;
        wait_pulses(p0 + 2, 10, "bp_release_pulse");
        if (n_pulses >= p0 + 2) check("bp_release_gap", pulse_cyc[p0 + 1], x0 + 2);
        wait_idle(1000, "bp_drain");

        // ---------------- push/pop while full ----------------
        resp_ready = 1'b0;
        max_level  = 0;
        for (int i = 0; i < 9; i++) push({16'h0D0D, 32'h0, 32'h3300_0000 + 32'(i)});
        check("full_level", level, 80'd8);
        check("full_in_ready", in_ready, 80'd0);
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push({16'h0E0E, 32'h0, 32'h4400_0000 + 32'(i)});
            check("full_level_after_refill", level, 80'd8);
        end
        check("full_max_level", max_level, 80'd8);
        wait_idle(2000, "full_drain");

        // ---------------- random loopback ----------------
        resp_ready = 1'b1;
        p0 = n_pulses;
        for (int i = 0; i < 100; i++) push({16'($urandom), $urandom, $urandom});
        wait_idle(3000, "loop_drain");
        check("loop_pulse_count", n_pulses - p0, 80'd100);

        check("cmd_queue_empty",  exp_cmd_q.size(),  80'd0);
        check("resp_queue_empty", exp_resp_q.size(), 80'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
